// File: rtl/dht11_poll_scheduler.sv
// Round-robin scheduler sharing one DHT11 reader among NUM_REQ requesters; SENSOR_CACHE_EN serves reqs in GAP from the last good reading.
// Latency: rd_start 1 cycle after a req is seen in IDLE; rsp_valid 1 cycle after rd_valid or after the WAIT timeout.
// Backpressure: none on rsp; requesters hold req until their rsp_valid strobe, and MIN_GAP idles the sensor between reads.
module dht11_poll_scheduler #(
    parameter int NUM_REQ = 3,
    parameter int ID_W    = 2,
    parameter int CNT_W   = 20,
    parameter int TIMEOUT = 200000,
    parameter int MIN_GAP = 100000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic               rsp_valid,
    output logic [ID_W-1:0]    rsp_id,
    output logic [7:0]         rsp_data,
    output logic               rsp_timeout,
    output logic               rsp_cached,
    output logic               busy,
    output logic               rd_start,
    input  logic               rd_valid,
    input  logic [7:0]         rd_temp,
    output logic [7:0]         err_count
);

    typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_RESP, S_GAP} state_t;

    state_t          state;
    logic [ID_W-1:0] last_gnt;
    logic [ID_W-1:0] gnt_id;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] gap_cnt;
    logic            arb_hit;
    logic [ID_W-1:0] arb_id;
    logic            grant_ok;

    // First requester above last_gnt wins; otherwise wrap to the lowest index.
    always_comb begin
        arb_hit = 1'b0;
        arb_id  = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!arb_hit && req[j] && (ID_W'(j) > last_gnt)) begin
                arb_hit = 1'b1;
                arb_id  = ID_W'(j);
            end
        end
        for (int j = 0; j < NUM_REQ; j++) begin
            if (!arb_hit && req[j]) begin
                arb_hit = 1'b1;
                arb_id  = ID_W'(j);
            end
        end
    end

`ifdef SENSOR_CACHE_EN
    logic [7:0] cache_q;
    logic       cache_vld;
    logic       dead;

    // The cycle after a cached serve is dead so the served requester can drop req.
    assign grant_ok = arb_hit && !dead;
`else
    assign grant_ok   = arb_hit;
    assign rsp_cached = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            last_gnt    <= ID_W'(NUM_REQ - 1);
            gnt_id      <= '0;
            timer       <= '0;
            gap_cnt     <= '0;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_data    <= '0;
            rsp_timeout <= 1'b0;
            busy        <= 1'b0;
            rd_start    <= 1'b0;
            err_count   <= '0;
`ifdef SENSOR_CACHE_EN
            rsp_cached  <= 1'b0;
            cache_q     <= '0;
            cache_vld   <= 1'b0;
            dead        <= 1'b0;
`endif
        end else begin
            rsp_valid <= 1'b0;
            rd_start  <= 1'b0;
`ifdef SENSOR_CACHE_EN
            dead      <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (grant_ok) begin
                        gnt_id   <= arb_id;
                        last_gnt <= arb_id;
                        rd_start <= 1'b1;
                        busy     <= 1'b1;
                        state    <= S_START;
                    end
                end
                S_START: begin
                    timer <= '0;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (rd_valid) begin
                        rsp_valid   <= 1'b1;
                        rsp_id      <= gnt_id;
                        rsp_data    <= rd_temp;
                        rsp_timeout <= 1'b0;
`ifdef SENSOR_CACHE_EN
                        rsp_cached  <= 1'b0;
`endif
                        state       <= S_RESP;
                    end else if (timer == CNT_W'(TIMEOUT - 1)) begin
                        rsp_valid   <= 1'b1;
                        rsp_id      <= gnt_id;
                        rsp_data    <= '0;
                        rsp_timeout <= 1'b1;
`ifdef SENSOR_CACHE_EN
                        rsp_cached  <= 1'b0;
`endif
                        state       <= S_RESP;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                S_RESP: begin
                    if (rsp_timeout) begin
                        if (err_count != 8'hFF)
                            err_count <= err_count + 1'b1;
`ifdef SENSOR_CACHE_EN
                        cache_vld <= 1'b0;
`endif
                    end else begin
`ifdef SENSOR_CACHE_EN
                        cache_q   <= rsp_data;
                        cache_vld <= 1'b1;
`endif
                    end
                    gap_cnt <= CNT_W'(MIN_GAP - 1);
                    busy    <= 1'b0;
                    state   <= S_GAP;
                end
                S_GAP: begin
                    if (gap_cnt == '0)
                        state <= S_IDLE;
                    else
                        gap_cnt <= gap_cnt - 1'b1;
`ifdef SENSOR_CACHE_EN
                    if (cache_vld && grant_ok) begin
                        last_gnt    <= arb_id;
                        rsp_valid   <= 1'b1;
                        rsp_id      <= arb_id;
                        rsp_data    <= cache_q;
                        rsp_timeout <= 1'b0;
                        rsp_cached  <= 1'b1;
                        dead        <= 1'b1;
                    end
`endif
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dht11_poll_scheduler.sv
// Scoreboard bench for dht11_poll_scheduler with TIMEOUT=50, MIN_GAP=20, NUM_REQ=3.
module tb_dht11_poll_scheduler;

    localparam int NUM_REQ = 3;
    localparam int ID_W    = 2;
    localparam int CNT_W   = 20;
    localparam int TIMEOUT = 50;
    localparam int MIN_GAP = 20;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [2:0]   req = 3'b000;
    logic         rd_valid = 1'b0;
    logic [7:0]   rd_temp = 8'd0;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [7:0]   rsp_data;
    logic         rsp_timeout;
    logic         rsp_cached;
    logic         busy;
    logic         rd_start;
    logic [7:0]   err_count;

    dht11_poll_scheduler #(
        .NUM_REQ(NUM_REQ), .ID_W(ID_W), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .MIN_GAP(MIN_GAP)
    ) dut (
        .clk(clk), .rst(rst), .req(req),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_timeout(rsp_timeout), .rsp_cached(rsp_cached), .busy(busy),
        .rd_start(rd_start), .rd_valid(rd_valid), .rd_temp(rd_temp), .err_count(err_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int n_start = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (rd_start) n_start <= n_start + 1;

    typedef struct {
        logic [1:0] id;
        logic [7:0] data;
        logic       to;
        logic       cached;
        int         lat;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    task automatic apply_reset();
        rst = 1'b1; req = '0; rd_valid = 1'b0; rd_temp = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic wait_rd_start(input int budget, output bit ok, output int at);
        ok = 1'b0; at = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (rd_start) begin ok = 1'b1; at = cyc; end
        end
    endtask

    task automatic wait_rsp(input int budget, output bit ok, output int at);
        ok = 1'b0; at = 0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1'b1; at = cyc; end
        end
    endtask

    // Reader answers on the d-th cycle after the rd_start cycle.
    task automatic drive_read(input int d, input logic [7:0] temp);
        repeat (d) @(posedge clk);
        #1 rd_valid = 1'b1; rd_temp = temp;
        @(posedge clk);
        #1 rd_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vectors++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_timeout, rsp_cached, busy, rd_start, err_count} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_outputs: got %h want 0",
                     {rsp_valid, rsp_id, rsp_data, rsp_timeout, rsp_cached, busy, rd_start, err_count});
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_single_read();
        bit ok; int t_req, t_st, t_rsp, n0; exp_t e;
        @(posedge clk); #1;
        n0 = n_start; req = 3'b001; t_req = cyc;
        wait_rd_start(5, ok, t_st);
        vectors++;
        if (!ok || t_st - t_req != 1 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL single_start: ok=%0d lat=%0d busy=%b want lat=1 busy=1", ok, t_st - t_req, busy);
        end
        sb.push_back('{id: 2'd0, data: 8'd25, to: 1'b0, cached: 1'b0, lat: 11});
        drive_read(10, 8'd25);
        wait_rsp(5, ok, t_rsp);
        e = sb.pop_front();
        vectors++;
        if (!ok || {rsp_id, rsp_data, rsp_timeout, rsp_cached} !== {e.id, e.data, e.to, e.cached} || t_rsp - t_st != e.lat) begin
            miscompares++;
            $display("FAIL single_rsp: ok=%0d id=%0d data=%0d to=%b c=%b lat=%0d want id=%0d data=%0d to=%b c=%b lat=%0d",
                     ok, rsp_id, rsp_data, rsp_timeout, rsp_cached, t_rsp - t_st, e.id, e.data, e.to, e.cached, e.lat);
        end
        @(posedge clk); #1 req = 3'b000;
        repeat (30) @(negedge clk);
        vectors++;
        if (n_start - n0 != 1 || busy !== 1'b0 || rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL single_count: starts=%0d busy=%b valid=%b want starts=1 busy=0 valid=0", n_start - n0, busy, rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        bit ok; int t_st, t_rsp, t_prev_st, t_prev_rsp; exp_t e;
        apply_reset();
        req = 3'b111;
        t_prev_st = -1000; t_prev_rsp = -1000;
        for (int r = 0; r < 4; r++) begin
            wait_rd_start(60, ok, t_st);
            vectors++;
            if (!ok || t_st - t_prev_st < MIN_GAP || t_st - t_prev_rsp < MIN_GAP) begin
                miscompares++;
                $display("FAIL rr_gap%0d: ok=%0d start_spacing=%0d rsp_to_start=%0d want >=%0d", r, ok,
                         t_st - t_prev_st, t_st - t_prev_rsp, MIN_GAP);
            end
            sb.push_back('{id: 2'(r % 3), data: 8'(60 + r), to: 1'b0, cached: 1'b0, lat: 11});
            drive_read(10, 8'(60 + r));
            wait_rsp(5, ok, t_rsp);
            e = sb.pop_front();
            vectors++;
            if (!ok || {rsp_id, rsp_data, rsp_timeout, rsp_cached} !== {e.id, e.data, e.to, e.cached} || t_rsp - t_st != e.lat) begin
                miscompares++;
                $display("FAIL rr_rsp%0d: ok=%0d id=%0d data=%0d to=%b lat=%0d want id=%0d data=%0d to=%b lat=%0d",
                         r, ok, rsp_id, rsp_data, rsp_timeout, t_rsp - t_st, e.id, e.data, e.to, e.lat);
            end
            t_prev_st = t_st; t_prev_rsp = t_rsp;
        end
        @(posedge clk); #1 req = 3'b000;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_timeout();
        bit ok; int t_st, t_rsp; exp_t e;
        apply_reset();
        req = 3'b010;
        for (int r = 0; r < 300; r++) begin
            wait_rd_start(60, ok, t_st);
            sb.push_back('{id: 2'd1, data: 8'd0, to: 1'b1, cached: 1'b0, lat: 51});
            wait_rsp(70, ok, t_rsp);
            e = sb.pop_front();
            vectors++;
            if (!ok || {rsp_id, rsp_data, rsp_timeout, rsp_cached} !== {e.id, e.data, e.to, e.cached} || t_rsp - t_st != e.lat) begin
                miscompares++;
                $display("FAIL timeout_rsp%0d: ok=%0d id=%0d data=%0d to=%b lat=%0d want id=%0d data=%0d to=%b lat=%0d",
                         r, ok, rsp_id, rsp_data, rsp_timeout, t_rsp - t_st, e.id, e.data, e.to, e.lat);
            end
            if (r == 0) begin
                repeat (2) @(negedge clk);
                vectors++;
                if (err_count !== 8'd1) begin
                    miscompares++;
                    $display("FAIL err_count_first: got %0d want 1", err_count);
                end
            end
        end
        @(posedge clk); #1 req = 3'b000;
        repeat (30) @(negedge clk);
        vectors++;
        if (err_count !== 8'd255) begin
            miscompares++;
            $display("FAIL err_count_sat: got %0d want 255", err_count);
        end
    endtask

    task automatic test_same_cycle_and_stray();
        bit ok; int t_st, t_rsp, n0; exp_t e;
        req = 3'b001;
        wait_rd_start(10, ok, t_st);
        sb.push_back('{id: 2'd0, data: 8'd77, to: 1'b0, cached: 1'b0, lat: 51});
        drive_read(TIMEOUT, 8'd77);
        wait_rsp(5, ok, t_rsp);
        e = sb.pop_front();
        vectors++;
        if (!ok || {rsp_id, rsp_data, rsp_timeout, rsp_cached} !== {e.id, e.data, e.to, e.cached} || t_rsp - t_st != e.lat) begin
            miscompares++;
            $display("FAIL valid_vs_timeout: ok=%0d id=%0d data=%0d to=%b lat=%0d want id=%0d data=%0d to=%b lat=%0d",
                     ok, rsp_id, rsp_data, rsp_timeout, t_rsp - t_st, e.id, e.data, e.to, e.lat);
        end
        @(posedge clk); #1 req = 3'b000;
        repeat (30) @(posedge clk);
        #1 rd_valid = 1'b1; rd_temp = 8'd99; n0 = n_start;
        @(posedge clk); #1 rd_valid = 1'b0;
        wait_rsp(8, ok, t_rsp);
        vectors++;
        if (ok || busy !== 1'b0 || n_start != n0 || rsp_data !== 8'd77) begin
            miscompares++;
            $display("FAIL stray_valid: rsp=%0d busy=%b starts=%0d data=%0d want rsp=0 busy=0 starts=0 data=77",
                     ok, busy, n_start - n0, rsp_data);
        end
    endtask

    task automatic test_reset_mid_read();
        bit ok; int t_st, t_rsp, t_rel; exp_t e;
        req = 3'b001;
        wait_rd_start(10, ok, t_st);
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk); @(negedge clk);
        vectors++;
        if ({rsp_valid, rsp_id, rsp_data, rsp_timeout, rsp_cached, busy, rd_start, err_count} !== 23'd0) begin
            miscompares++;
            $display("FAIL reset_mid_read: got %h want 0",
                     {rsp_valid, rsp_id, rsp_data, rsp_timeout, rsp_cached, busy, rd_start, err_count});
        end
        @(posedge clk); #1 rst = 1'b0; t_rel = cyc;
        wait_rd_start(10, ok, t_st);
        vectors++;
        if (!ok || t_st - t_rel != 1) begin
            miscompares++;
            $display("FAIL restart_no_gap: ok=%0d lat=%0d want lat=1", ok, t_st - t_rel);
        end
        sb.push_back('{id: 2'd0, data: 8'd12, to: 1'b0, cached: 1'b0, lat: 11});
        drive_read(10, 8'd12);
        wait_rsp(5, ok, t_rsp);
        e = sb.pop_front();
        vectors++;
        if (!ok || {rsp_id, rsp_data, rsp_timeout, rsp_cached} !== {e.id, e.data, e.to, e.cached} || t_rsp - t_st != e.lat) begin
            miscompares++;
            $display("FAIL post_reset_rsp: ok=%0d id=%0d data=%0d to=%b lat=%0d want id=%0d data=%0d to=%b lat=%0d",
                     ok, rsp_id, rsp_data, rsp_timeout, t_rsp - t_st, e.id, e.data, e.to, e.lat);
        end
        @(posedge clk); #1 req = 3'b000;
        repeat (30) @(negedge clk);
    endtask

    task automatic test_cache();
        bit ok; int t_st, t_rsp, t_rsp0, n0; exp_t e;
        apply_reset();
        n0 = n_start;
        req = 3'b001;
        wait_rd_start(10, ok, t_st);
        sb.push_back('{id: 2'd0, data: 8'd30, to: 1'b0, cached: 1'b0, lat: 11});
        drive_read(10, 8'd30);
        wait_rsp(5, ok, t_rsp0);
        e = sb.pop_front();
        vectors++;
        if (!ok || {rsp_id, rsp_data, rsp_timeout, rsp_cached} !== {e.id, e.data, e.to, e.cached} || t_rsp0 - t_st != e.lat) begin
            miscompares++;
            $display("FAIL cache_fill: ok=%0d id=%0d data=%0d to=%b lat=%0d want id=%0d data=%0d to=%b lat=%0d",
                     ok, rsp_id, rsp_data, rsp_timeout, t_rsp0 - t_st, e.id, e.data, e.to, e.lat);
        end
        @(posedge clk); #1 req = 3'b100;
`ifdef SENSOR_CACHE_EN
        sb.push_back('{id: 2'd2, data: 8'd30, to: 1'b0, cached: 1'b1, lat: -1});
        wait_rsp(5, ok, t_rsp);
        e = sb.pop_front();
        vectors++;
        if (!ok || {rsp_id, rsp_data, rsp_timeout, rsp_cached} !== {e.id, e.data, e.to, e.cached} || n_start - n0 != 1) begin
            miscompares++;
            $display("FAIL cached_serve: ok=%0d id=%0d data=%0d to=%b c=%b starts=%0d want id=%0d data=%0d to=%b c=%b starts=1",
                     ok, rsp_id, rsp_data, rsp_timeout, rsp_cached, n_start - n0, e.id, e.data, e.to, e.cached);
        end
        @(posedge clk); #1 req = 3'b000;
        repeat (30) @(negedge clk);
        vectors++;
        if (n_start - n0 != 1) begin
            miscompares++;
            $display("FAIL cached_no_read: starts=%0d want 1", n_start - n0);
        end
`else
        wait_rd_start(40, ok, t_st);
        vectors++;
        if (!ok || t_st - t_rsp0 < MIN_GAP || rsp_cached !== 1'b0) begin
            miscompares++;
            $display("FAIL gap_req_waits: ok=%0d rsp_to_start=%0d cached=%b want >=%0d cached=0",
                     ok, t_st - t_rsp0, rsp_cached, MIN_GAP);
        end
        sb.push_back('{id: 2'd2, data: 8'd31, to: 1'b0, cached: 1'b0, lat: 11});
        drive_read(10, 8'd31);
        wait_rsp(5, ok, t_rsp);
        e = sb.pop_front();
        vectors++;
        if (!ok || {rsp_id, rsp_data, rsp_timeout, rsp_cached} !== {e.id, e.data, e.to, e.cached} || t_rsp - t_st != e.lat) begin
            miscompares++;
            $display("FAIL gap_req_read: ok=%0d id=%0d data=%0d to=%b c=%b lat=%0d want id=%0d data=%0d to=%b c=%b lat=%0d",
                     ok, rsp_id, rsp_data, rsp_timeout, rsp_cached, t_rsp - t_st, e.id, e.data, e.to, e.cached, e.lat);
        end
        @(posedge clk); #1 req = 3'b000;
        repeat (30) @(negedge clk);
`endif
    endtask

    initial begin
        test_reset();
        test_single_read();
`ifndef SENSOR_CACHE_EN
        test_round_robin();
`endif
        test_timeout();
        test_same_cycle_and_stray();
        test_reset_mid_read();
        test_cache();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
